fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage directly upstream of the decode controller. Holds the PC, issues word fetches to instruction memory over a req/ack handshake, and captures each returned word in an instruction register. Presents the instruction, its PC and its opcode field (the controller's opcode input) to decode with a valid/ready handshake. Accepts a single-cycle redirect (branch/jump) and discards any in-flight fetch made stale by it.

## Interface
- PC_W, 32, PC and memory address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- iClk  in  1  clock, all state on rising edge
- iRstN  in  1  asynchronous, active-low reset
- oImemReq  out  1  fetch request; held high until iImemAck
- oImemAddr  out  PC_W  fetch address; stable while oImemReq high
- iImemAck  in  1  memory done; iImemRdata valid this cycle
- iImemRdata  in  32  instruction word
- oInstrValid  out  1  oInstr/oPc/oOp valid for decode
- iInstrReady  in  1  decode consumes when high with oInstrValid
- oInstr  out  32  instruction register
- oPc  out  PC_W  address oInstr was fetched from
- oOp  out  6  oInstr[31:26], feeds controller opcode input
- iRedirect  in  1  one-cycle pulse: refetch from iRedirectPc
- iRedirectPc  in  PC_W  redirect target, word-aligned

## Operation
- Reset (async, immediate): state IDLE, pc=RESET_PC, oInstr=0, oPc=0, oInstrValid=0, oImemReq=0, oImemAddr=RESET_PC, pending target=0.
- IDLE: req low; next edge -> REQ. Only reached via reset.
- REQ: oImemReq=1, oImemAddr=pc. On iImemAck: oInstr<=iImemRdata, oPc<=pc, pc<=pc+4 (mod 2^PC_W), -> HOLD. No ack: stay.
- HOLD: oInstrValid=1, oImemReq=0. iInstrReady high: -> REQ next cycle. Otherwise hold oInstr/oPc stable.
- DRAIN: oImemReq=1 with old address (transaction can't be withdrawn). On iImemAck: data discarded, pc<=pending target, -> REQ.
- Redirect rules:
  - REQ, no ack same cycle: pending<=iRedirectPc, -> DRAIN.
  - REQ with ack same cycle: data discarded, IR untouched, pc<=iRedirectPc, -> REQ.
  - HOLD: oInstrValid drops next cycle, pc<=iRedirectPc, -> REQ. If iInstrReady also high, the instruction is consumed (decode saw it); the redirect still wins for the next PC.
  - DRAIN: pending overwritten (newest redirect wins); with ack same cycle, new target used.
  - IDLE: pc<=iRedirectPc, -> REQ.
- iImemAck while oImemReq low: ignored.
- oOp is a pure slice of oInstr, never separately registered.
- Low two bits of iRedirectPc are not checked; alignment is the source's responsibility.

## Timing
- Zero-wait memory (ack in request cycle): REQ at cycle n -> oInstrValid at n+1.
- N-cycle ack: valid one cycle after the ack.
- With ready held high: REQ, HOLD alternate, one instruction per 2 cycles max; no overlap of fetch with HOLD.
- Redirect-to-request: one cycle from HOLD/IDLE/REQ-with-ack; from DRAIN, one cycle after the stale ack.
- All outputs registered or decoded from state only; no combinational path from iInstrReady or iRedirect to oImemReq/oImemAddr.

## Structure
- Shared package mips_pkg: fetch_state_t enum {IDLE, REQ, HOLD, DRAIN}, INSTR_W=32, OP_HI=31, OP_LO=26, PC_INC=4, OP_LW=6'b100011.
- Single module; no sub-module. PC incrementer and next-PC mux inline.

## Test plan
- Reset with RESET_PC=0: all outputs at reset values during reset. First cycle after release: req=0. Next cycle: req=1, addr=0.
- Zero-wait memory returns 32'h8C08_0004 at addr 0, ready high: oInstrValid=1, oInstr=8C080004, oOp=6'b100011, oPc=0. Next req addr=4. Steady-state valid every 2nd cycle.
- Backpressure: ready low 3 cycles in HOLD: valid, oInstr and oPc stable, req=0. Ready high: req with addr=4 the following cycle.
- Ack delayed 3 cycles; redirect to 32'h40 in the 1st wait cycle: addr stays 0 until ack, oInstrValid never rises for that word, next req addr=32'h40. A second redirect to 32'h80 during DRAIN yields addr=32'h80.
- Redirect to 32'h100 in the ack cycle: no valid. Redirect to 32'h200 in HOLD with ready high: valid falls, next req addr=32'h200.
- iRstN dropped mid-wait (req high, no ack): immediate return to reset values. A late iImemAck after release is ignored. Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the instruction-fetch front end.
//   fetch_state_t : fetch FSM states (IDLE, REQ, HOLD, DRAIN)
//   INSTR_W       : instruction word width
//   OP_HI/OP_LO   : opcode field bounds inside an instruction word
//   PC_INC        : sequential PC step in bytes
//   OP_LW         : load-word opcode
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam int INSTR_W = 32;
  localparam int OP_HI   = 31;
  localparam int OP_LO   = 26;
  localparam int PC_INC  = 4;
  localparam logic [5:0] OP_LW = 6'b100011;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the decode controller.
// Holds the PC, fetches one word at a time over a req/ack handshake,
// captures it in the instruction register and offers it to decode with a
// valid/ready handshake. A one-cycle redirect retargets the PC; a fetch
// already on the bus when the redirect arrives is drained and discarded.
// Ports:
//   iClk, iRstN               clock, async active-low reset
//   oImemReq, oImemAddr       fetch request and address (to memory)
//   iImemAck, iImemRdata      fetch completion and returned word
//   oInstrValid, iInstrReady  handshake to decode
//   oInstr, oPc, oOp          instruction, its address, its opcode field
//   iRedirect, iRedirectPc    redirect pulse and target
module fetch_unit
  import mips_pkg::*;
#(
  parameter int                PC_W     = 32,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic                 iClk,
  input  logic                 iRstN,
  output logic                 oImemReq,
  output logic [PC_W-1:0]      oImemAddr,
  input  logic                 iImemAck,
  input  logic [INSTR_W-1:0]   iImemRdata,
  output logic                 oInstrValid,
  input  logic                 iInstrReady,
  output logic [INSTR_W-1:0]   oInstr,
  output logic [PC_W-1:0]      oPc,
  output logic [5:0]           oOp,
  input  logic                 iRedirect,
  input  logic [PC_W-1:0]      iRedirectPc
);

  fetch_state_t         state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [PC_W-1:0]      pend_q, pend_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [PC_W-1:0]      opc_q, opc_d;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      instr_q <= '0;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    unique case (state_q)
      IDLE: begin
        if (iRedirect) pc_d = iRedirectPc;
        state_d = REQ;
      end
      REQ: begin
        if (iImemAck) begin
          if (iRedirect) begin
            // Returned word is already stale: drop it and refetch.
            pc_d    = iRedirectPc;
            state_d = REQ;
          end else begin
            instr_d = iImemRdata;
            opc_d   = pc_q;
            pc_d    = pc_q + PC_W'(PC_INC);
            state_d = HOLD;
          end
        end else if (iRedirect) begin
          // The outstanding request cannot be withdrawn; park the target.
          pend_d  = iRedirectPc;
          state_d = DRAIN;
        end
      end
      HOLD: begin
        // Redirect wins over a simultaneous consume for the next PC.
        if (iRedirect) begin
          pc_d    = iRedirectPc;
          state_d = REQ;
        end else if (iInstrReady) begin
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (iRedirect) pend_d = iRedirectPc;
        if (iImemAck) begin
          pc_d    = iRedirect ? iRedirectPc : pend_q;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // pc_q only advances on a completed, kept fetch, so while draining it
  // still holds the address of the outstanding request.
  assign oImemReq    = (state_q == REQ) || (state_q == DRAIN);
  assign oImemAddr   = pc_q;
  assign oInstrValid = (state_q == HOLD);
  assign oInstr      = instr_q;
  assign oPc         = opc_q;
  assign oOp         = instr_q[OP_HI:OP_LO];

endmodule
